// File: rtl/pump_ctrl_multi.sv
// Multi-nozzle fuel pump controller: per-channel price table, preset by cost or volume,
// nozzle hold/resume with timeout, registered outputs.

module pump_price_rf #(
   parameter int NCH = 3,
   parameter int PW  = 16,
   parameter int CW  = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [CW-1:0] wr_addr,
   input  logic [PW-1:0] wr_data,
   input  logic [CW-1:0] rd_addr,
   output logic [PW-1:0] rd_data
);
   logic [PW-1:0] price_q [NCH];
   logic [PW-1:0] price_d [NCH];

   // Addresses that decode to no entry fall through as no-ops.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         price_d[i] = price_q[i];
         if (we && (wr_addr == CW'(i))) price_d[i] = wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rd_addr == CW'(i)) rd_data = price_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) price_q[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) price_q[i] <= price_d[i];
      end
   end
endmodule

// state | meaning
// IDLE  | waiting for an acceptable start, display holds last vol/cost
// ARM   | transaction latched, waiting for nozzle valve
// FILL  | pump on, one unit every TICK_DIV cycles
// HOLD  | valve closed, tick frozen, timeout running
// DONE  | one-cycle completion, done pulse
module pump_ctrl_multi #(
   parameter int NCH      = 3,
   parameter int AW       = 24,
   parameter int PW       = 16,
   parameter int TICK_DIV = 4,
   parameter int HOLD_MAX = 1000,
   localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           stop,
   input  logic           valve,
   input  logic [NCH-1:0] select,
   input  logic           mode,
   input  logic [AW-1:0]  preset,
   input  logic           price_we,
   input  logic [CW-1:0]  price_addr,
   input  logic [PW-1:0]  price_data,
   output logic [NCH-1:0] gas,
   output logic [AW-1:0]  vol,
   output logic [AW-1:0]  cost,
   output logic           busy,
   output logic           done,
   output logic           err
);
   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW  = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam int AW1 = AW + 1;
   localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_MAX - 1);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_FILL, S_HOLD, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [NCH-1:0] ch_q, ch_d;
   logic           mode_q, mode_d;
   logic [AW-1:0]  preset_q, preset_d;
   logic [PW-1:0]  lprice_q, lprice_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic [AW-1:0]  vol_q, vol_d;
   logic [AW-1:0]  cost_q, cost_d;
   logic [NCH-1:0] gas_q, gas_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           err_q, err_d;

   logic [CW-1:0]  sel_idx;
   logic [PW-1:0]  sel_price;
   logic           start_ok;
   logic [AW:0]    unit_sum;
   logic           unit_ovf;
   logic [AW-1:0]  vol_inc;
   logic           cost_end;

   pump_price_rf #(.NCH(NCH), .PW(PW), .CW(CW)) u_price (
      .clk     (clk),
      .reset   (reset),
      .we      (price_we),
      .wr_addr (price_addr),
      .wr_data (price_data),
      .rd_addr (sel_idx),
      .rd_data (sel_price)
   );

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NCH; i++) begin
         if (select[i]) sel_idx = CW'(i);
      end
   end

   assign start_ok = $onehot(select) && (preset != '0) && (sel_price != '0) &&
                     (mode || (preset >= AW'(sel_price)));

   // One extra bit catches a unit that would push cost past full scale.
   assign unit_sum = AW1'(cost_q) + AW1'(lprice_q);
   assign unit_ovf = unit_sum[AW];
   assign vol_inc  = vol_q + AW'(1);
   assign cost_end = (AW1'(unit_sum[AW-1:0]) + AW1'(lprice_q)) > AW1'(preset_q);

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      mode_d   = mode_q;
      preset_d = preset_q;
      lprice_d = lprice_q;
      tick_d   = tick_q;
      hold_d   = hold_q;
      vol_d    = vol_q;
      cost_d   = cost_q;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (start_ok) begin
                  ch_d     = select;
                  mode_d   = mode;
                  preset_d = preset;
                  lprice_d = sel_price;
                  vol_d    = '0;
                  cost_d   = '0;
                  tick_d   = TICK_LOAD;
                  state_d  = S_ARM;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ARM: begin
            if (stop)       state_d = S_DONE;
            else if (valve) state_d = S_FILL;
         end
         S_FILL: begin
            if (stop) begin
               state_d = S_DONE;
            end else if (tick_q == '0) begin
               tick_d = TICK_LOAD;
               if (unit_ovf) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  vol_d  = vol_inc;
                  cost_d = unit_sum[AW-1:0];
                  if (mode_q ? (vol_inc == preset_q) : cost_end) begin
                     state_d = S_DONE;
                  end else if (!valve) begin
                     state_d = S_HOLD;
                     hold_d  = HOLD_LOAD;
                  end
               end
            end else begin
               tick_d = tick_q - TW'(1);
               if (!valve) begin
                  state_d = S_HOLD;
                  hold_d  = HOLD_LOAD;
               end
            end
         end
         S_HOLD: begin
            if (stop) begin
               state_d = S_DONE;
            end else if (valve) begin
               state_d = S_FILL;
            end else if (hold_q == '0) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      gas_d  = (state_d == S_FILL) ? ch_q : '0;
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ch_q     <= '0;
         mode_q   <= 1'b0;
         preset_q <= '0;
         lprice_q <= '0;
         tick_q   <= '0;
         hold_q   <= '0;
         vol_q    <= '0;
         cost_q   <= '0;
         gas_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         mode_q   <= mode_d;
         preset_q <= preset_d;
         lprice_q <= lprice_d;
         tick_q   <= tick_d;
         hold_q   <= hold_d;
         vol_q    <= vol_d;
         cost_q   <= cost_d;
         gas_q    <= gas_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign gas  = gas_q;
   assign vol  = vol_q;
   assign cost = cost_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
endmodule
